// File: rtl/fd_pipe_queue.sv
// Fetch-to-decode circular queue carrying {arm, instr, payload} with a valid/ready handshake.
// Optional FD_BUBBLE_NOP_EN: drive a mode-matched NOP on instr_d whenever valid_d is low.
module fd_pipe_queue #(
  parameter  int DATA_W  = 64,
  parameter  int INSTR_W = 32,
  parameter  int DEPTH   = 2,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_f,
  input  logic [INSTR_W-1:0] instr_f,
  input  logic               arm_f,
  input  logic [DATA_W-1:0]  payload_f,
  output logic               ready_f,
  input  logic               stall_d,
  input  logic               flush_d,
  output logic               valid_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic               arm_d,
  output logic [DATA_W-1:0]  payload_d,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] r_instr   [DEPTH];
  logic               r_arm     [DEPTH];
  logic [DATA_W-1:0]  r_payload [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_enq;
  logic               w_deq;
  logic               w_valid;
  logic               w_ready;

  assign w_ready = (r_count != CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_enq   = valid_f & w_ready;
  assign w_deq   = w_valid & ~stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr[i]   <= '0;
        r_arm[i]     <= 1'b0;
        r_payload[i] <= '0;
      end
    end else if (flush_d) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_instr[r_wptr]   <= instr_f;
        r_arm[r_wptr]     <= arm_f;
        r_payload[r_wptr] <= payload_f;
        r_wptr            <= r_wptr + PTR_W'(1);
      end
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FD_BUBBLE_NOP_EN
  // Mode of the last head that left the queue (dequeued or flushed out) selects the bubble NOP.
  logic r_last_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_arm <= 1'b0;
    else if ((flush_d | w_deq) & w_valid)
      r_last_arm <= r_arm[r_rptr];
  end

  always_comb begin
    payload_d = r_payload[r_rptr];
    arm_d     = r_last_arm;
    instr_d   = r_last_arm ? INSTR_W'(32'hE1A0_0000) : INSTR_W'(32'h0000_0013);
    if (w_valid) begin
      arm_d   = r_arm[r_rptr];
      instr_d = r_instr[r_rptr];
    end
  end
`else
  always_comb begin
    instr_d   = r_instr[r_rptr];
    arm_d     = r_arm[r_rptr];
    payload_d = r_payload[r_rptr];
  end
`endif

  assign ready_f = w_ready;
  assign valid_d = w_valid;
  assign count   = r_count;

endmodule

// File: tb/tb_fd_pipe_queue.sv
// Directed bench for fd_pipe_queue: a DEPTH=2 instance for handshake/flush/bubble/reset
// and a DEPTH=4 instance for a wrapping stream with alternating stalls.
module tb_fd_pipe_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DEPTH=2 instance
  logic        v2 = 0, a2 = 0, st2 = 0, fl2 = 0;
  logic [31:0] i2 = '0;
  logic [63:0] p2 = '0;
  logic        rdy2, vd2, ad2;
  logic [31:0] id2;
  logic [63:0] pd2;
  logic [1:0]  c2;

  // DEPTH=4 instance
  logic        v4 = 0, a4 = 0, st4 = 0, fl4 = 0;
  logic [31:0] i4 = '0;
  logic [63:0] p4 = '0;
  logic        rdy4, vd4, ad4;
  logic [31:0] id4;
  logic [63:0] pd4;
  logic [2:0]  c4;

  fd_pipe_queue #(.DATA_W(64), .INSTR_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .valid_f(v2), .instr_f(i2), .arm_f(a2), .payload_f(p2),
    .ready_f(rdy2), .stall_d(st2), .flush_d(fl2), .valid_d(vd2), .instr_d(id2),
    .arm_d(ad2), .payload_d(pd2), .count(c2));

  fd_pipe_queue #(.DATA_W(64), .INSTR_W(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .valid_f(v4), .instr_f(i4), .arm_f(a4), .payload_f(p4),
    .ready_f(rdy4), .stall_d(st4), .flush_d(fl4), .valid_d(vd4), .instr_d(id4),
    .arm_d(ad4), .payload_d(pd4), .count(c4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt, wr_idx, rd_idx, max_cnt, cyc;
    logic acc, dq;

    // Reset state
    #2;
    chk("rst_valid", 64'(vd2), 64'd0);
    chk("rst_ready", 64'(rdy2), 64'd1);
    chk("rst_count", 64'(c2), 64'd0);
`ifdef FD_BUBBLE_NOP_EN
    chk("rst_instr", 64'(id2), 64'h13);
`else
    chk("rst_instr", 64'(id2), 64'h0);
`endif
    chk("rst_payload", pd2, 64'h0);
    #1 rst_n = 1'b1;

    // Single entry, one-cycle latency, then drained
    v2 = 1; i2 = 32'h0050_0093; a2 = 0; p2 = 64'h0000_1000_0000_1004;
    step();
    chk("t1_valid", 64'(vd2), 64'd1);
    chk("t1_instr", 64'(id2), 64'h0050_0093);
    chk("t1_payload", pd2, 64'h0000_1000_0000_1004);
    chk("t1_count", 64'(c2), 64'd1);
    chk("t1_ready", 64'(rdy2), 64'd1);
    v2 = 0;
    step();
    chk("t1_drain_valid", 64'(vd2), 64'd0);
    chk("t1_drain_count", 64'(c2), 64'd0);

    // Back-pressure: stall while pushing A, B, C
    st2 = 1; v2 = 1; i2 = 32'hAAAA_0001; p2 = 64'hA;
    step();
    chk("bp_count1", 64'(c2), 64'd1);
    chk("bp_ready1", 64'(rdy2), 64'd1);
    chk("bp_headA1", 64'(id2), 64'hAAAA_0001);
    i2 = 32'hBBBB_0002; p2 = 64'hB;
    step();
    chk("bp_count2", 64'(c2), 64'd2);
    chk("bp_ready2", 64'(rdy2), 64'd0);
    chk("bp_headA2", 64'(id2), 64'hAAAA_0001);
    i2 = 32'hCCCC_0003; p2 = 64'hC;
    step();
    chk("bp_full_count", 64'(c2), 64'd2);
    chk("bp_full_ready", 64'(rdy2), 64'd0);
    chk("bp_full_headA", 64'(id2), 64'hAAAA_0001);
    chk("bp_full_payA", pd2, 64'hA);
    st2 = 0;
    step();
    chk("bp_headB", 64'(id2), 64'hBBBB_0002);
    chk("bp_cnt_after_A", 64'(c2), 64'd1);
    chk("bp_ready_after_A", 64'(rdy2), 64'd1);
    step();
    chk("bp_headC", 64'(id2), 64'hCCCC_0003);
    chk("bp_payC", pd2, 64'hC);
    chk("bp_cnt_after_B", 64'(c2), 64'd1);
    v2 = 0;
    step();
    chk("bp_drained_valid", 64'(vd2), 64'd0);
    chk("bp_drained_count", 64'(c2), 64'd0);

    // Flush with a same-cycle fetch entry
    st2 = 1; v2 = 1; i2 = 32'h1111_0001; a2 = 0;
    step();
    i2 = 32'h2222_0002;
    step();
    chk("fl_pre_count", 64'(c2), 64'd2);
    fl2 = 1; i2 = 32'h3333_0003;
    step();
    chk("fl_count", 64'(c2), 64'd0);
    chk("fl_valid", 64'(vd2), 64'd0);
    chk("fl_ready", 64'(rdy2), 64'd1);
    fl2 = 0; v2 = 0;
    step();
    chk("fl_no_ghost_valid", 64'(vd2), 64'd0);
    chk("fl_no_ghost_count", 64'(c2), 64'd0);
    st2 = 0;

    // Bubble contents after an ARM entry then a RISC-V entry drain
    v2 = 1; i2 = 32'hE081_1002; a2 = 1;
    step();
    chk("arm_valid", 64'(vd2), 64'd1);
    chk("arm_mode", 64'(ad2), 64'd1);
    v2 = 0;
    step();
    chk("arm_bubble_valid", 64'(vd2), 64'd0);
`ifdef FD_BUBBLE_NOP_EN
    chk("arm_bubble_instr", 64'(id2), 64'hE1A0_0000);
    chk("arm_bubble_mode", 64'(ad2), 64'd1);
`else
    chk("arm_bubble_instr", 64'(id2), 64'h2222_0002);
    chk("arm_bubble_mode", 64'(ad2), 64'd0);
`endif
    v2 = 1; i2 = 32'h00A0_0113; a2 = 0;
    step();
    chk("rv_valid", 64'(vd2), 64'd1);
    chk("rv_instr", 64'(id2), 64'h00A0_0113);
    v2 = 0;
    step();
`ifdef FD_BUBBLE_NOP_EN
    chk("rv_bubble_instr", 64'(id2), 64'h13);
    chk("rv_bubble_mode", 64'(ad2), 64'd0);
`else
    chk("rv_bubble_instr", 64'(id2), 64'hE081_1002);
    chk("rv_bubble_mode", 64'(ad2), 64'd1);
`endif

    // DEPTH=4 streaming: 10 pushes, stall on every other cycle, checked against a bench FIFO count
    exp_cnt = 0; wr_idx = 0; rd_idx = 0; max_cnt = 0; cyc = 0;
    while (rd_idx < 10 && cyc < 80) begin
      v4  = (wr_idx < 10);
      i4  = 32'hC0DE_0000 + 32'(wr_idx);
      a4  = wr_idx[0];
      p4  = 64'(wr_idx) << 32 | 64'(wr_idx + 4);
      st4 = cyc[0];
      acc = v4 && (exp_cnt != 4);
      dq  = (exp_cnt != 0) && !st4;
      chk("s_ready", 64'(rdy4), 64'(exp_cnt != 4));
      chk("s_valid", 64'(vd4), 64'(exp_cnt != 0));
      if (dq) begin
        chk("s_order_instr", 64'(id4), 64'(32'hC0DE_0000 + 32'(rd_idx)));
        chk("s_order_arm", 64'(ad4), 64'(rd_idx[0]));
      end
      step();
      if (acc) wr_idx++;
      if (dq) rd_idx++;
      exp_cnt = exp_cnt + int'(acc) - int'(dq);
      if (int'(c4) > max_cnt) max_cnt = int'(c4);
      chk("s_count", 64'(c4), 64'(exp_cnt));
      cyc++;
    end
    chk("s_all_drained", 64'(rd_idx), 64'd10);
    chk("s_max_count", 64'(max_cnt), 64'd4);
    v4 = 0; st4 = 0;

    // Asynchronous reset mid-cycle with two entries held
    st2 = 1; v2 = 1; i2 = 32'h5555_0001; a2 = 1;
    step();
    i2 = 32'h6666_0002;
    step();
    chk("ar_pre_count", 64'(c2), 64'd2);
    v2 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(vd2), 64'd0);
    chk("ar_count", 64'(c2), 64'd0);
    chk("ar_ready", 64'(rdy2), 64'd1);
`ifdef FD_BUBBLE_NOP_EN
    chk("ar_instr", 64'(id2), 64'h13);
`else
    chk("ar_instr", 64'(id2), 64'h0);
`endif
    chk("ar_mode", 64'(ad2), 64'd0);
    #3 rst_n = 1'b1;
    st2 = 0;
    step();
    chk("ar_post_count", 64'(c2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
